// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Main control FSM for a multicycle MIPS datapath. It sequences
//               fetch / decode / execute / memory / writeback and drives the
//               datapath mux selects, strobes and the 3-bit ALUOp.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         in_Opcode_6,
  input  logic               in_Zero,
  input  logic               in_JumpRegister,
  input  logic               in_MemReady,
  output logic [2:0]         o_ALUOp_3,
  output logic               o_PCWrite,
  output logic               o_IorD,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_IRWrite,
  output logic               o_RegWrite,
  output logic [1:0]         o_RegDst_2,
  output logic [1:0]         o_MemtoReg_2,
  output logic               o_ALUSrcA,
  output logic [1:0]         o_ALUSrcB_2,
  output logic               o_ZeroExtend,
  output logic [1:0]         o_PCSource_2,
  output logic               o_IllegalOp,
  output logic [STATE_W-1:0] o_State_4
);

  localparam logic [STATE_W-1:0] c_S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] c_S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] c_S_EXEC_R   = STATE_W'(2);
  localparam logic [STATE_W-1:0] c_S_R_WB     = STATE_W'(3);
  localparam logic [STATE_W-1:0] c_S_MEM_ADDR = STATE_W'(4);
  localparam logic [STATE_W-1:0] c_S_MEM_RD   = STATE_W'(5);
  localparam logic [STATE_W-1:0] c_S_MEM_WB   = STATE_W'(6);
  localparam logic [STATE_W-1:0] c_S_MEM_WR   = STATE_W'(7);
  localparam logic [STATE_W-1:0] c_S_BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] c_S_JUMP     = STATE_W'(9);
  localparam logic [STATE_W-1:0] c_S_EXEC_I   = STATE_W'(10);
  localparam logic [STATE_W-1:0] c_S_I_WB     = STATE_W'(11);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;

  // State register: the only storage in the unit; reset forces FETCH.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state logic: decode dispatches on the opcode held in the IR.
  always_comb begin
    w_next = c_S_FETCH;
    case (r_state)
      c_S_FETCH:    w_next = in_MemReady ? c_S_DECODE : c_S_FETCH;
      c_S_DECODE: begin
        case (in_Opcode_6)
          c_OP_RTYPE:                             w_next = c_S_EXEC_R;
          c_OP_LW, c_OP_SW:                       w_next = c_S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE:                     w_next = c_S_BRANCH;
          c_OP_J, c_OP_JAL:                       w_next = c_S_JUMP;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: w_next = c_S_EXEC_I;
          default:                                w_next = c_S_FETCH;
        endcase
      end
      c_S_EXEC_R:   w_next = in_JumpRegister ? c_S_FETCH : c_S_R_WB;
      c_S_MEM_ADDR: w_next = (in_Opcode_6 == c_OP_LW) ? c_S_MEM_RD : c_S_MEM_WR;
      c_S_MEM_RD:   w_next = in_MemReady ? c_S_MEM_WB : c_S_MEM_RD;
      c_S_MEM_WR:   w_next = in_MemReady ? c_S_FETCH : c_S_MEM_WR;
      c_S_EXEC_I:   w_next = c_S_I_WB;
      default:      w_next = c_S_FETCH;
    endcase
    if (!reset) w_next = c_S_FETCH;
  end

  // Output decode: Moore outputs per state, plus the few handshake/flag
  // qualified strobes; reset low overrides everything to the idle pattern.
  always_comb begin
    o_ALUOp_3    = 3'b000;
    o_PCWrite    = 1'b0;
    o_IorD       = 1'b0;
    o_MemRead    = 1'b0;
    o_MemWrite   = 1'b0;
    o_IRWrite    = 1'b0;
    o_RegWrite   = 1'b0;
    o_RegDst_2   = 2'b00;
    o_MemtoReg_2 = 2'b00;
    o_ALUSrcA    = 1'b0;
    o_ALUSrcB_2  = 2'b00;
    o_ZeroExtend = 1'b0;
    o_PCSource_2 = 2'b00;
    o_IllegalOp  = 1'b0;
    case (r_state)
      c_S_FETCH: begin
        o_MemRead   = 1'b1;
        o_ALUSrcB_2 = 2'b01;
        o_ALUOp_3   = 3'b100;
        o_IRWrite   = in_MemReady;
        o_PCWrite   = in_MemReady;
      end
      c_S_DECODE: begin
        o_ALUSrcB_2 = 2'b11;
        o_ALUOp_3   = 3'b100;
        case (in_Opcode_6)
          c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_BNE, c_OP_J, c_OP_JAL,
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: o_IllegalOp = 1'b0;
          default:                                  o_IllegalOp = 1'b1;
        endcase
      end
      c_S_EXEC_R: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp_3 = 3'b111;
        if (in_JumpRegister) begin
          o_PCSource_2 = 2'b11;
          o_PCWrite    = 1'b1;
        end
      end
      c_S_R_WB: begin
        o_RegDst_2 = 2'b01;
        o_RegWrite = 1'b1;
      end
      c_S_MEM_ADDR: begin
        o_ALUSrcA   = 1'b1;
        o_ALUSrcB_2 = 2'b10;
        o_ALUOp_3   = 3'b011;
      end
      c_S_MEM_RD: begin
        o_IorD    = 1'b1;
        o_MemRead = 1'b1;
      end
      c_S_MEM_WB: begin
        o_MemtoReg_2 = 2'b01;
        o_RegWrite   = 1'b1;
      end
      c_S_MEM_WR: begin
        o_IorD     = 1'b1;
        o_MemWrite = 1'b1;
      end
      c_S_BRANCH: begin
        o_ALUSrcA    = 1'b1;
        o_ALUOp_3    = 3'b001;
        o_PCSource_2 = 2'b01;
        o_PCWrite    = ((in_Opcode_6 == c_OP_BEQ) &&  in_Zero) ||
                       ((in_Opcode_6 == c_OP_BNE) && !in_Zero);
      end
      c_S_JUMP: begin
        o_PCSource_2 = 2'b10;
        o_PCWrite    = 1'b1;
        o_ALUOp_3    = 3'b010;
        if (in_Opcode_6 == c_OP_JAL) begin
          o_RegDst_2   = 2'b10;
          o_MemtoReg_2 = 2'b10;
          o_RegWrite   = 1'b1;
        end
      end
      c_S_EXEC_I, c_S_I_WB: begin
        o_ALUSrcA   = 1'b1;
        o_ALUSrcB_2 = 2'b10;
        case (in_Opcode_6)
          c_OP_ANDI: begin o_ALUOp_3 = 3'b110; o_ZeroExtend = 1'b1; end
          c_OP_ORI:  begin o_ALUOp_3 = 3'b101; o_ZeroExtend = 1'b1; end
          c_OP_LUI:  o_ALUOp_3 = 3'b000;
          default:   o_ALUOp_3 = 3'b100;
        endcase
        // ALU result is already latched in ALUOut; the write-back step only
        // adds the register-file write with rt as destination.
        if (r_state == c_S_I_WB) o_RegWrite = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      o_ALUOp_3    = 3'b010;
      o_PCWrite    = 1'b0;
      o_IorD       = 1'b0;
      o_MemRead    = 1'b0;
      o_MemWrite   = 1'b0;
      o_IRWrite    = 1'b0;
      o_RegWrite   = 1'b0;
      o_RegDst_2   = 2'b00;
      o_MemtoReg_2 = 2'b00;
      o_ALUSrcA    = 1'b0;
      o_ALUSrcB_2  = 2'b00;
      o_ZeroExtend = 1'b0;
      o_PCSource_2 = 2'b00;
      o_IllegalOp  = 1'b0;
    end
  end

  assign o_State_4 = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. A reference
//               model tracks the instruction plan and predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0, jr = 1'b0, rdy = 1'b0;
  logic [2:0] o_ALUOp_3;
  logic       o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_RegWrite;
  logic [1:0] o_RegDst_2, o_MemtoReg_2, o_ALUSrcB_2, o_PCSource_2;
  logic       o_ALUSrcA, o_ZeroExtend, o_IllegalOp;
  logic [3:0] o_State_4;

  int n_tests = 0;
  int n_fail  = 0;
  int m_st    = 0;      // model's idea of the current control step
  int plan[$];          // remaining steps of the instruction in flight

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .in_Opcode_6(opcode), .in_Zero(zero),
    .in_JumpRegister(jr), .in_MemReady(rdy), .o_ALUOp_3(o_ALUOp_3),
    .o_PCWrite(o_PCWrite), .o_IorD(o_IorD), .o_MemRead(o_MemRead),
    .o_MemWrite(o_MemWrite), .o_IRWrite(o_IRWrite), .o_RegWrite(o_RegWrite),
    .o_RegDst_2(o_RegDst_2), .o_MemtoReg_2(o_MemtoReg_2), .o_ALUSrcA(o_ALUSrcA),
    .o_ALUSrcB_2(o_ALUSrcB_2), .o_ZeroExtend(o_ZeroExtend),
    .o_PCSource_2(o_PCSource_2), .o_IllegalOp(o_IllegalOp), .o_State_4(o_State_4)
  );

  always #5 clk = ~clk;

  // Steps an instruction walks through after DECODE, by opcode class.
  function automatic void build_plan(input logic [5:0] op);
    plan.delete();
    case (op)
      6'h00:                      begin plan.push_back(2); plan.push_back(3); end
      6'h23: begin plan.push_back(4); plan.push_back(5); plan.push_back(6); end
      6'h2b:                      begin plan.push_back(4); plan.push_back(7); end
      6'h04, 6'h05:               plan.push_back(8);
      6'h02, 6'h03:               plan.push_back(9);
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin plan.push_back(10); plan.push_back(11); end
      default: ;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                      6'h08, 6'h0c, 6'h0d, 6'h0f};
  endfunction

  // Expected output vector for one cycle, from the step and current inputs.
  function automatic logic [23:0] model_out(input int st, input logic [5:0] op,
      input logic z, input logic j, input logic r, input logic rs);
    logic [2:0] alu = 3'd0;
    logic pcw = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, sa = 0, ze = 0, ill = 0;
    logic [1:0] rd = 0, mtr = 0, sb = 0, pcs = 0;
    if (!rs) alu = 3'b010;
    else case (st)
      0:  begin mr = 1; sb = 2'b01; alu = 3'b100; pcw = r; irw = r; end
      1:  begin sb = 2'b11; alu = 3'b100; ill = !legal(op); end
      2:  begin sa = 1; alu = 3'b111; if (j) begin pcs = 2'b11; pcw = 1; end end
      3:  begin rd = 2'b01; rw = 1; end
      4:  begin sa = 1; sb = 2'b10; alu = 3'b011; end
      5:  begin iord = 1; mr = 1; end
      6:  begin mtr = 2'b01; rw = 1; end
      7:  begin iord = 1; mw = 1; end
      8:  begin sa = 1; alu = 3'b001; pcs = 2'b01; pcw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
      9:  begin pcs = 2'b10; pcw = 1; alu = 3'b010;
                if (op == 6'h03) begin rd = 2'b10; mtr = 2'b10; rw = 1; end end
      10, 11: begin
        sa = 1; sb = 2'b10; rw = (st == 11);
        alu = (op == 6'h0c) ? 3'b110 : (op == 6'h0d) ? 3'b101 : (op == 6'h0f) ? 3'b000 : 3'b100;
        ze  = (op == 6'h0c) || (op == 6'h0d);
      end
      default: ;
    endcase
    return {alu, pcw, iord, mr, mw, irw, rw, rd, mtr, sa, sb, ze, pcs, ill, 4'(st)};
  endfunction

  // Advance the model by one clock edge.
  function automatic void model_step(input logic [5:0] op, input logic j,
      input logic r, input logic rs);
    if (!rs) begin m_st = 0; plan.delete(); return; end
    if ((m_st == 0 || m_st == 5 || m_st == 7) && !r) return;
    if (m_st == 1) build_plan(op);
    if (m_st == 2 && j) plan.delete();
    m_st = (m_st == 0) ? 1 : (plan.size() > 0) ? plan.pop_front() : 0;
  endfunction

  // One clock: drive inputs, compare all outputs against the model, advance.
  task automatic cyc(input logic [5:0] op, input logic z, input logic j,
      input logic r, input logic rs);
    logic [23:0] expv, obs;
    @(negedge clk);
    opcode = op; zero = z; jr = j; rdy = r; reset = rs;
    #1;
    expv = model_out(m_st, op, z, j, r, rs);
    obs  = {o_ALUOp_3, o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite,
            o_RegWrite, o_RegDst_2, o_MemtoReg_2, o_ALUSrcA, o_ALUSrcB_2,
            o_ZeroExtend, o_PCSource_2, o_IllegalOp, o_State_4};
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL cycle_cmp step=%0d op=%h got=%h expected=%h", m_st, op, obs, expv);
    end
    model_step(op, j, r, rs);
  endtask

  task automatic lit(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  initial begin
    int cnt;
    logic [5:0] ops[12];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h3f};
    reset = 1'b0;
    @(posedge clk);
    m_st = 0;

    // Reset held low two cycles: idle pattern while sitting in FETCH.
    cyc(6'h00, 0, 0, 1, 0); lit("rst_aluop", o_ALUOp_3, 2); lit("rst_memread", o_MemRead, 0);
    cyc(6'h00, 0, 0, 1, 0); lit("rst_state", o_State_4, 0);

    // ADD: 0,1,2,3.
    cyc(6'h00, 0, 0, 1, 1); lit("add_s0", o_State_4, 0); lit("add_irw", o_IRWrite, 1);
    cyc(6'h00, 0, 0, 1, 1); lit("add_s1", o_State_4, 1);
    cyc(6'h00, 0, 0, 1, 1); lit("add_s2", o_State_4, 2); lit("add_aluop", o_ALUOp_3, 7);
    cyc(6'h00, 0, 0, 1, 1); lit("add_s3", o_State_4, 3); lit("add_rw", o_RegWrite, 1);
    lit("add_rd", o_RegDst_2, 1);

    // LW with three memory stalls: 8 cycles.
    cyc(6'h23, 0, 0, 1, 1); lit("lw_s0", o_State_4, 0);
    cyc(6'h23, 0, 0, 1, 1);
    cyc(6'h23, 0, 0, 1, 1); lit("lw_s4", o_State_4, 4);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(6'h23, 0, 0, (i == 3), 1);
      if (o_State_4 == 5 && o_MemRead && o_IorD) cnt++;
    end
    lit("lw_rd_cycles", cnt, 4);
    cyc(6'h23, 0, 0, 1, 1); lit("lw_s6", o_State_4, 6); lit("lw_mtr", o_MemtoReg_2, 1);
    lit("lw_rw", o_RegWrite, 1);

    // BEQ taken, BNE not taken (Zero=1 for both).
    cyc(6'h04, 1, 0, 1, 1); lit("beq_s0", o_State_4, 0);
    cyc(6'h04, 1, 0, 1, 1);
    cyc(6'h04, 1, 0, 1, 1); lit("beq_pcw", o_PCWrite, 1); lit("beq_pcs", o_PCSource_2, 1);
    cyc(6'h05, 1, 0, 1, 1); lit("bne_s0", o_State_4, 0);
    cyc(6'h05, 1, 0, 1, 1);
    cyc(6'h05, 1, 0, 1, 1); lit("bne_s8", o_State_4, 8); lit("bne_pcw", o_PCWrite, 0);

    // JAL.
    cyc(6'h03, 0, 0, 1, 1); lit("jal_s0", o_State_4, 0);
    cyc(6'h03, 0, 0, 1, 1);
    cyc(6'h03, 0, 0, 1, 1); lit("jal_pcs", o_PCSource_2, 2); lit("jal_pcw", o_PCWrite, 1);
    lit("jal_rw", o_RegWrite, 1); lit("jal_rd", o_RegDst_2, 2); lit("jal_mtr", o_MemtoReg_2, 2);

    // JR: EXEC_R jumps straight back to FETCH.
    cyc(6'h00, 0, 1, 1, 1); lit("jr_s0", o_State_4, 0);
    cyc(6'h00, 0, 1, 1, 1);
    cyc(6'h00, 0, 1, 1, 1); lit("jr_pcs", o_PCSource_2, 3); lit("jr_pcw", o_PCWrite, 1);

    // ORI.
    cyc(6'h0d, 0, 0, 1, 1); lit("ori_s0", o_State_4, 0);
    cyc(6'h0d, 0, 0, 1, 1);
    cyc(6'h0d, 0, 0, 1, 1); lit("ori_s10", o_State_4, 10); lit("ori_alu", o_ALUOp_3, 5);
    lit("ori_ze", o_ZeroExtend, 1);
    cyc(6'h0d, 0, 0, 1, 1); lit("ori_s11", o_State_4, 11); lit("ori_wb_alu", o_ALUOp_3, 5);

    // Illegal opcode.
    cyc(6'h3f, 0, 0, 1, 1);
    cyc(6'h3f, 0, 0, 1, 1); lit("ill_pulse", o_IllegalOp, 1);

    // SW aborted by reset during a MemReady wait.
    cyc(6'h2b, 0, 0, 1, 1); lit("ill_back", o_State_4, 0);
    cyc(6'h2b, 0, 0, 1, 1);
    cyc(6'h2b, 0, 0, 1, 1);
    cyc(6'h2b, 0, 0, 0, 1); lit("sw_s7", o_State_4, 7); lit("sw_mw", o_MemWrite, 1);
    cyc(6'h2b, 0, 0, 0, 0); lit("sw_rst_mw", o_MemWrite, 0); lit("sw_rst_rw", o_RegWrite, 0);
    lit("sw_rst_pcw", o_PCWrite, 0);
    cyc(6'h2b, 0, 0, 1, 1); lit("sw_abort_fetch", o_State_4, 0);

    // Randomised run: opcode only changes while the model is in FETCH.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] op;
      op = opcode;
      if (m_st == 0) op = ($urandom_range(0, 12) == 12) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      cyc(op, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 49) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle MIPS main control FSM. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALUOp consumed by the ALU control decoder and receives that decoder's jump-register flag back.
- Sits between instruction register, datapath muxes, register file and a memory port with a ready handshake.

Parameters:
- STATE_W, 4, width of state register and of o_State_4 debug output.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- in_Opcode_6  input  6  IR[31:26]
- in_Zero  input  1  ALU zero flag
- in_JumpRegister  input  1  jr flag from ALU control, valid when ALUOp=111
- in_MemReady  input  1  memory completes current read/write this cycle
- o_ALUOp_3  output  3  111 R, 100 add(ADDI/PC), 101 ORI, 110 ANDI, 000 LUI, 011 LW/SW, 001 branch, 010 J/no-op
- o_PCWrite  output  1  PC load enable
- o_IorD  output  1  0 PC address, 1 ALUOut address
- o_MemRead  output  1  memory read strobe
- o_MemWrite  output  1  memory write strobe
- o_IRWrite  output  1  instruction register load
- o_RegWrite  output  1  register file write
- o_RegDst_2  output  2  00 rt, 01 rd, 10 $31
- o_MemtoReg_2  output  2  00 ALUOut, 01 MDR, 10 PC
- o_ALUSrcA  output  1  0 PC, 1 A
- o_ALUSrcB_2  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- o_ZeroExtend  output  1  1 zero-extend immediate (ANDI/ORI)
- o_PCSource_2  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- o_IllegalOp  output  1  one-cycle pulse on unsupported opcode
- o_State_4  output  STATE_W  current state, debug

Behaviour:
- Moore outputs decode combinationally from the state register, except o_PCWrite in FETCH/BRANCH/EXEC_R and o_IRWrite. The state register updates only on the rising edge of clk.
- While reset=0, all strobes (PCWrite, MemRead, MemWrite, IRWrite, RegWrite, IllegalOp) are forced 0, muxes are 0 and ALUOp is 010. State loads FETCH on the edge.
- Unlisted outputs are 0 in each state.
- States and encodings:
  - FETCH(0): IorD=0, MemRead=1, SrcA=0, SrcB=01, ALUOp=100, PCSource=00. Holds while MemReady=0. On MemReady=1: IRWrite=1 and PCWrite=1 that cycle, go to DECODE. PC+4 happens exactly once per fetch.
  - DECODE(1): SrcA=0, SrcB=11, ALUOp=100 (branch target into ALUOut). Next state by opcode:
    - 000000 → EXEC_R
    - 100011 or 101011 → MEM_ADDR
    - 000100 or 000101 → BRANCH
    - 000010 or 000011 → JUMP
    - 001000/001100/001101/001111 → EXEC_I
    - other → FETCH, with IllegalOp=1 for this cycle.
  - EXEC_R(2): SrcA=1, SrcB=00, ALUOp=111. If in_JumpRegister=1: PCSource=11, PCWrite=1, go FETCH. Else go R_WB.
  - R_WB(3): RegDst=01, MemtoReg=00, RegWrite=1, go FETCH.
  - MEM_ADDR(4): SrcA=1, SrcB=10, ALUOp=011. Go MEM_RD for 100011, MEM_WR for 101011.
  - MEM_RD(5): IorD=1, MemRead=1. Hold until MemReady=1, then go MEM_WB.
  - MEM_WB(6): RegDst=00, MemtoReg=01, RegWrite=1, go FETCH.
  - MEM_WR(7): IorD=1, MemWrite=1. Hold until MemReady=1, then go FETCH. MemWrite stays high every waiting cycle.
  - BRANCH(8): SrcA=1, SrcB=00, ALUOp=001, PCSource=01. PCWrite = (op 000100 & Zero) | (op 000101 & ~Zero). Go FETCH.
  - JUMP(9): PCSource=10, PCWrite=1, ALUOp=010. For 000011 also RegDst=10, MemtoReg=10, RegWrite=1 (PC already +4). Go FETCH.
  - EXEC_I(10): SrcA=1, SrcB=10. ALUOp: ADDI 100, ANDI 110, ORI 101, LUI 000. ZeroExtend=1 for ANDI/ORI. Go I_WB.
  - I_WB(11): ALUOp, SrcB and ZeroExtend held as in EXEC_I. RegDst=00, MemtoReg=00, RegWrite=1, go FETCH.
- Opcode is sampled from the IR, which is stable after FETCH. The FSM does not register the opcode.
- Unused encodings 12–15 go to FETCH next cycle with all strobes 0.
- Reset low mid-instruction (including during a MemReady wait) aborts it: no strobe asserts, and the next state is FETCH.
- Cycles per instruction with MemReady=1:
  - R: 4
  - jr: 3
  - LW: 5
  - SW: 4
  - branch: 3
  - J/JAL: 3
  - I-type: 4
  - illegal: 2
- Each MemReady stall cycle adds 1.

Test Plan:
- Reset low 2 cycles, then high, MemReady=1, IR=ADD (op 000000, funct 100000) → o_State_4: 0,1,2,3,0. RegWrite=1 only in state 3 with RegDst=01. ALUOp=111 in state 2.
- LW with MemReady low for 3 cycles in MEM_RD → MemRead, IorD=1 held for 4 cycles, then MEM_WB with MemtoReg=01, RegWrite=1. Total 8 cycles.
- BEQ with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. BNE with Zero=1 → PCWrite=0. Both return to FETCH after 3 cycles.
- JAL → JUMP state: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. JR (in_JumpRegister=1 in EXEC_R) → PCSource=11, PCWrite=1, no R_WB.
- ORI → EXEC_I/I_WB with ALUOp=101, ZeroExtend=1. Opcode 111111 → IllegalOp pulse in DECODE, then FETCH.
- Reset pulled low during MEM_WR while MemReady=0 → MemWrite=0 that cycle, next state FETCH, no RegWrite/PCWrite.
